// File: rtl/imm_gen_pipe.sv
// Immediate generator feeding a 2-entry in-order result FIFO with tag and illegal flag.
// Optional feature: define IMM_ZIMM_EN to decode ImmSrc=101 as the zero-extended CSR zimm.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      Instr,
  input  logic [2:0]       ImmSrc,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [XLEN-1:0]  ImmExt,
  output logic [TAG_W-1:0] out_tag,
  output logic             Illegal,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  localparam logic [2:0] SRC_I    = 3'b000;
  localparam logic [2:0] SRC_S    = 3'b001;
  localparam logic [2:0] SRC_B    = 3'b010;
  localparam logic [2:0] SRC_J    = 3'b011;
  localparam logic [2:0] SRC_U    = 3'b100;
`ifdef IMM_ZIMM_EN
  localparam logic [2:0] SRC_ZIMM = 3'b101;
`endif

  logic [XLEN-1:0]  dec_imm;
  logic             dec_ill;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             wr_ptr;
  logic             rd_ptr;
  logic             wr_ptr_nxt;
  logic             rd_ptr_nxt;
  logic             accept;
  logic             pop;

  logic [XLEN-1:0]  mem_imm [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];
  logic             mem_ill [DEPTH];

  logic [XLEN-1:0]  head_imm_nxt;
  logic [TAG_W-1:0] head_tag_nxt;
  logic             head_ill_nxt;

  // Opcode field carries no immediate bits in any supported format.
  logic unused_opcode;
  assign unused_opcode = ^Instr[6:0];

  // Immediate decode; every format sign-extends from Instr[31].
  always_comb begin
    dec_imm = '0;
    dec_ill = 1'b0;
    case (ImmSrc)
      SRC_I: dec_imm = {{(XLEN-12){Instr[31]}}, Instr[31:20]};
      SRC_S: dec_imm = {{(XLEN-12){Instr[31]}}, Instr[31:25], Instr[11:7]};
      SRC_B: dec_imm = {{(XLEN-12){Instr[31]}}, Instr[7], Instr[30:25], Instr[11:8], 1'b0};
      SRC_J: dec_imm = {{(XLEN-20){Instr[31]}}, Instr[19:12], Instr[20], Instr[30:21], 1'b0};
      SRC_U: dec_imm = XLEN'($signed({Instr[31:12], 12'b0}));
`ifdef IMM_ZIMM_EN
      SRC_ZIMM: dec_imm = XLEN'(Instr[19:15]);
`endif
      default: begin
        dec_imm = '0;
        dec_ill = 1'b1;
      end
    endcase
  end

  // Handshakes use only registered flags, so in_ready never sees out_ready combinationally.
  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_comb begin
    wr_ptr_nxt = wr_ptr ^ accept;
    rd_ptr_nxt = rd_ptr ^ pop;
    count_nxt  = count;
    case ({accept, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Next head: the freshly decoded entry bypasses storage when it lands at the read slot.
  always_comb begin
    head_imm_nxt = ImmExt;
    head_tag_nxt = out_tag;
    head_ill_nxt = Illegal;
    if (count_nxt != CNT_W'(0)) begin
      if (accept && (wr_ptr == rd_ptr_nxt)) begin
        head_imm_nxt = dec_imm;
        head_tag_nxt = in_tag;
        head_ill_nxt = dec_ill;
      end else begin
        head_imm_nxt = mem_imm[rd_ptr_nxt];
        head_tag_nxt = mem_tag[rd_ptr_nxt];
        head_ill_nxt = mem_ill[rd_ptr_nxt];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count     <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      ImmExt    <= '0;
      out_tag   <= '0;
      Illegal   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_imm[i] <= '0;
        mem_tag[i] <= '0;
        mem_ill[i] <= 1'b0;
      end
    end else begin
      count     <= count_nxt;
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      in_ready  <= (count_nxt != CNT_W'(DEPTH));
      out_valid <= (count_nxt != CNT_W'(0));
      ImmExt    <= head_imm_nxt;
      out_tag   <= head_tag_nxt;
      Illegal   <= head_ill_nxt;
      if (accept) begin
        mem_imm[wr_ptr] <= dec_imm;
        mem_tag[wr_ptr] <= in_tag;
        mem_ill[wr_ptr] <= dec_ill;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: 32- and 64-bit instances checked against a queue model plus literal pins.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic [2:0]  src;
  logic [4:0]  tag;
  logic        in_valid;
  logic        out_ready;

  logic        rdy32, vld32, ill32;
  logic [31:0] imm32;
  logic [4:0]  tag32;
  logic        rdy64, vld64, ill64;
  logic [63:0] imm64;
  logic [4:0]  tag64;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .Instr(instr), .ImmSrc(src), .in_tag(tag),
    .in_valid(in_valid), .in_ready(rdy32), .ImmExt(imm32), .out_tag(tag32),
    .Illegal(ill32), .out_valid(vld32), .out_ready(out_ready)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .rst_n(rst_n), .Instr(instr), .ImmSrc(src), .in_tag(tag),
    .in_valid(in_valid), .in_ready(rdy64), .ImmExt(imm64), .out_tag(tag64),
    .Illegal(ill64), .out_valid(vld64), .out_ready(out_ready)
  );

  typedef struct {
    longint     imm;
    logic [4:0] tag;
    bit         ill;
  } exp_t;

  exp_t q[$];
  bit   rst_zero = 1'b1;

  // Immediate value as a signed number built from the field weights.
  function automatic longint model_imm(input logic [31:0] w, input logic [2:0] s, output bit ill);
    longint v;
    ill = 1'b0;
    v   = 0;
    case (s)
      3'd0: begin v = longint'(w[31:20]); if (w[31]) v -= 4096; end
      3'd1: begin v = longint'(w[31:25]) * 32 + longint'(w[11:7]); if (w[31]) v -= 4096; end
      3'd2: begin
        v = longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
        if (w[31]) v -= 4096;
      end
      3'd3: begin
        v = longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
        if (w[31]) v -= 64'sd1048576;
      end
      3'd4: begin v = longint'(w[31:12]) * 4096; if (w[31]) v -= 64'sd4294967296; end
`ifdef IMM_ZIMM_EN
      3'd5: v = longint'(w[19:15]);
`endif
      default: begin v = 0; ill = 1'b1; end
    endcase
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Model update on each rising edge from the inputs presented in that cycle.
  always @(posedge clk) begin
    bit   acc, pp, ill;
    exp_t e;
    if (!rst_n) begin
      q.delete();
      rst_zero = 1'b1;
    end else begin
      acc = in_valid && (q.size() < 2);
      pp  = out_ready && (q.size() > 0);
      if (pp) void'(q.pop_front());
      if (acc) begin
        e.imm = model_imm(instr, src, ill);
        e.ill = ill;
        e.tag = tag;
        q.push_back(e);
        rst_zero = 1'b0;
      end
    end
  end

  // Every-cycle compare on the falling edge.
  always @(negedge clk) begin
    if (started) begin
      chk("m_vld32", 64'(vld32), 64'(q.size() > 0));
      chk("m_rdy32", 64'(rdy32), 64'(q.size() < 2));
      chk("m_vld64", 64'(vld64), 64'(q.size() > 0));
      chk("m_rdy64", 64'(rdy64), 64'(q.size() < 2));
      if (q.size() > 0) begin
        chk("m_imm32", 64'(imm32), 64'(q[0].imm[31:0]));
        chk("m_tag32", 64'(tag32), 64'(q[0].tag));
        chk("m_ill32", 64'(ill32), 64'(q[0].ill));
        chk("m_imm64", imm64, q[0].imm);
        chk("m_tag64", 64'(tag64), 64'(q[0].tag));
        chk("m_ill64", 64'(ill64), 64'(q[0].ill));
      end else if (rst_zero) begin
        chk("m_zero32", {31'b0, ill32, 27'b0, tag32}, 64'd0);
        chk("m_zimm32", 64'(imm32), 64'd0);
        chk("m_zero64", {58'b0, ill64, tag64}, 64'd0);
        chk("m_zimm64", imm64, 64'd0);
      end
    end
  end

  task automatic step(input logic r, input logic v, input logic [31:0] w, input logic [2:0] s,
                      input logic [4:0] t, input logic o);
    @(posedge clk);
    #1;
    rst_n = r; in_valid = v; instr = w; src = s; tag = t; out_ready = o;
  endtask

  logic [31:0] vec [8] = '{32'hFFF00093, 32'h800000B7, 32'h7FF0A0A3, 32'h8E5F1FEF,
                           32'h000F8073, 32'h12345678, 32'hFEDCBA98, 32'h00000FE3};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr = '0; src = '0; tag = '0; out_ready = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    started = 1'b1;
    step(1, 0, 0, 0, 0, 0);
    chk("reset_vld", 64'(vld32), 64'd0);
    chk("reset_rdy", 64'(rdy32), 64'd1);
    chk("reset_imm", imm64, 64'd0);

    // I-type -1 and U-type sign extension into the upper word.
    step(1, 1, 32'hFFF00093, 3'b000, 5'd4, 1);
    step(1, 1, 32'h800000B7, 3'b100, 5'd5, 1);
    chk("i_vld", 64'(vld32), 64'd1);
    chk("i_imm32", 64'(imm32), 64'hFFFFFFFF);
    chk("i_ill", 64'(ill32), 64'd0);
    step(1, 0, 0, 0, 0, 1);
    chk("u_imm64", imm64, 64'hFFFFFFFF80000000);
    chk("u_imm32", 64'(imm32), 64'h80000000);
    step(1, 0, 0, 0, 0, 1);

    // Fill to two, third held until a slot frees; order and stall stability.
    step(1, 1, 32'h00100093, 3'b000, 5'd1, 0);
    step(1, 1, 32'h00200093, 3'b000, 5'd2, 0);
    step(1, 1, 32'h00300093, 3'b000, 5'd3, 0);
    chk("full_rdy", 64'(rdy32), 64'd0);
    step(1, 1, 32'h00300093, 3'b000, 5'd3, 0);
    chk("stall_tag", 64'(tag32), 64'd1);
    chk("stall_imm", 64'(imm32), 64'd1);
    step(1, 1, 32'h00300093, 3'b000, 5'd3, 1);
    chk("stall_tag2", 64'(tag32), 64'd1);
    step(1, 1, 32'h00300093, 3'b000, 5'd3, 1);
    chk("pop_tag2", 64'(tag32), 64'd2);
    chk("pop_rdy", 64'(rdy32), 64'd1);
    step(1, 0, 0, 0, 0, 1);
    chk("pop_tag3", 64'(tag32), 64'd3);
    chk("pop_imm3", 64'(imm32), 64'd3);
    step(1, 0, 0, 0, 0, 1);
    chk("drain_vld", 64'(vld32), 64'd0);

    // Illegal code and the optional zimm code.
    step(1, 1, 32'hFFFFFFFF, 3'b111, 5'd7, 1);
    step(1, 1, 32'h000F8073, 3'b101, 5'd8, 1);
    chk("ill_flag", 64'(ill32), 64'd1);
    chk("ill_imm", 64'(imm32), 64'd0);
    step(1, 0, 0, 0, 0, 1);
`ifdef IMM_ZIMM_EN
    chk("zimm_imm", 64'(imm32), 64'h1F);
    chk("zimm_ill", 64'(ill32), 64'd0);
`else
    chk("zimm_ill", 64'(ill32), 64'd1);
    chk("zimm_imm", 64'(imm32), 64'd0);
`endif
    step(1, 0, 0, 0, 0, 1);

    // Count=1 with simultaneous accept and pop.
    step(1, 1, 32'h00A00093, 3'b000, 5'd10, 0);
    step(1, 1, 32'h00B00093, 3'b000, 5'd11, 1);
    chk("sim_tagA", 64'(tag32), 64'd10);
    step(1, 0, 0, 0, 0, 0);
    chk("sim_vld", 64'(vld32), 64'd1);
    chk("sim_tagB", 64'(tag32), 64'd11);
    chk("sim_immB", 64'(imm32), 64'd11);

    // Reset while full with handshakes asserted.
    step(1, 1, 32'h00C00093, 3'b000, 5'd12, 0);
    step(0, 1, 32'hFFF00093, 3'b000, 5'd13, 1);
    chk("pre_rst_rdy", 64'(rdy32), 64'd0);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_vld", 64'(vld32), 64'd0);
    chk("rst_rdy", 64'(rdy32), 64'd1);
    chk("rst_out", {imm64[57:0], ill64, tag64}, 64'd0);

    // Directed table across all formats with a mixed downstream pattern.
    for (int i = 0; i < 32; i++) begin
      step(1, (i % 4) != 3, vec[i % 8], 3'(i % 8), 5'(i), (i % 3) != 0);
    end
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    chk("final_vld", 64'(vld32), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, immediate output width; legal values 32 or 64.
REQ-002 Parameter TAG_W, default 5, width of the sideband tag carried alongside each immediate.
REQ-003 clk  input  1  single clock for all state; rising-edge sampled.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 Instr  input  32  instruction word to decode.
REQ-006 ImmSrc  input  3  immediate format select.
REQ-007 in_tag  input  TAG_W  sideband tag, stored with the result.
REQ-008 in_valid  input  1  upstream presents Instr/ImmSrc/in_tag.
REQ-009 in_ready  output  1  block can accept this cycle.
REQ-010 ImmExt  output  XLEN  extended immediate at buffer head.
REQ-011 out_tag  output  TAG_W  tag at buffer head.
REQ-012 Illegal  output  1  head entry had an unsupported ImmSrc.
REQ-013 out_valid  output  1  head entry present.
REQ-014 out_ready  input  1  downstream consumes the head this cycle.

Function
REQ-015 Formats SHALL be: 000 I {Instr[31:20]}; 001 S {Instr[31:25],Instr[11:7]}; 010 B {Instr[7],Instr[30:25],Instr[11:8],0}; 011 J {Instr[19:12],Instr[20],Instr[30:21],0}; 100 U {Instr[31:12],12'b0}. Each result is sign-extended from Instr[31] to XLEN.
REQ-016 For XLEN=64, the U format SHALL sign-extend bit 31 into bits 63:32.
REQ-017 Unsupported ImmSrc SHALL store ImmExt=0 with Illegal=1; supported codes SHALL store Illegal=0.
REQ-018 Results SHALL be held in a 2-entry in-order FIFO (entries: ImmExt, tag, Illegal); occupancy count ranges 0..2.
REQ-019 Accept = in_valid & in_ready; pop = out_valid & out_ready.
REQ-020 in_ready = (count<2); it SHALL NOT depend combinationally on out_ready.
REQ-021 out_valid = (count>0); ImmExt, out_tag and Illegal SHALL come straight from the head entry register.
REQ-022 Latency: an entry accepted in cycle N SHALL be visible at the head in cycle N+1 when the FIFO was empty or popped to empty in cycle N.
REQ-023 Simultaneous accept and pop at count=1: count stays 1, and the new entry becomes head next cycle.
REQ-024 With count=2, the block SHALL NOT accept; a pop frees a slot that is visible as in_ready=1 the next cycle.
REQ-025 Head outputs SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 Pointers SHALL wrap modulo 2; ordering is strictly FIFO.
REQ-027 Inputs SHALL be ignored whenever accept=0.

Reset
REQ-028 When rst_n=0 at a rising edge: count=0 and pointers=0, so out_valid=0 and in_ready=1; ImmExt=0, out_tag=0, Illegal=0.
REQ-029 Reset mid-operation SHALL discard all buffered entries; any accept or pop in that cycle has no effect.

Configuration
REQ-030 Macro IMM_ZIMM_EN: when defined, ImmSrc=101 SHALL produce the CSR zimm format, {XLEN-5 zeros, Instr[19:15]} (zero-extended), with Illegal=0.
REQ-031 Without IMM_ZIMM_EN, ImmSrc=101 SHALL be treated as unsupported per REQ-017.

Verification
REQ-032 Instr=32'hFFF00093, ImmSrc=000, accept with out_ready=1 -> next cycle out_valid=1, ImmExt=32'hFFFFFFFF, Illegal=0.
REQ-033 Instr=32'h800000B7, ImmSrc=100, XLEN=64 -> ImmExt=64'hFFFFFFFF80000000.
REQ-034 Three back-to-back accepts (tags 1,2,3) with out_ready=0 -> in_ready drops after 2 accepts; raising out_ready yields tags 1,2,3 in order, head stable while stalled.
REQ-035 Accept with ImmSrc=111 -> Illegal=1, ImmExt=0; ImmSrc=101 with Instr[19:15]=5'h1F -> ImmExt=32'h1F when IMM_ZIMM_EN is defined, Illegal=1 otherwise.
REQ-036 Count=1, simultaneous accept and pop -> out_valid stays 1 and the head switches to the new tag the next cycle.
REQ-037 Count=2, rst_n=0 for one cycle -> out_valid=0, in_ready=1, and all outputs are zero the next cycle.
